// File: rtl/round_pkg.sv
// rtl/round_pkg.sv - rounding mode encoding, stage-1 flag bundle and round-up decision
// Shared by the lane datapath and the stream wrapper.
package round_pkg;

  typedef enum logic [2:0] {
    RM_RNE   = 3'd0,
    RM_RHAZ  = 3'd1,
    RM_FLOOR = 3'd2,
    RM_TRUNC = 3'd3,
    RM_CEIL  = 3'd4
  } round_mode_e;

  typedef struct packed {
    logic gt_half;
    logic eq_half;
    logic nz;
    logic sign;
  } round_flags_t;

  // Unused codes 5..7 fall into the default arm and round to nearest even.
  function automatic logic round_up(input logic [2:0] mode, input round_flags_t f,
                                    input logic q_lsb);
    logic r;
    case (mode)
      RM_RHAZ:  r = f.gt_half | (f.eq_half & ~f.sign);
      RM_FLOOR: r = 1'b0;
      RM_TRUNC: r = f.nz & f.sign;
      RM_CEIL:  r = f.nz;
      default:  r = f.gt_half | (f.eq_half & q_lsb);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/round_sat_lane.sv
// rtl/round_sat_lane.sv - one lane: shift/flag/round-bit stage then add/saturate stage
// Stage registers load only when the wrapper moves a beat into them.
module round_sat_lane
  import round_pkg::*;
#(
  parameter int W_IN      = 24,
  parameter int W_OUT     = 16,
  parameter int IS_SIGNED = 1,
  parameter int SHIFT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_ld1,
  input  logic               i_ld2,
  input  logic [W_IN-1:0]    i_din,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic [2:0]         i_mode,
  output logic [W_OUT-1:0]   o_dout,
  output logic               o_sat
);

  localparam logic [W_IN:0] P_ONE = (W_IN + 1)'(1);
  localparam logic signed [W_IN:0] P_MAX = (IS_SIGNED != 0) ?
      signed'((P_ONE << (W_OUT - 1)) - P_ONE) : signed'((P_ONE << W_OUT) - P_ONE);
  localparam logic signed [W_IN:0] P_MIN = (IS_SIGNED != 0) ?
      signed'(-(P_ONE << (W_OUT - 1))) : signed'((W_IN + 1)'(0));

  logic signed [W_IN:0] w_ext;
  logic signed [W_IN:0] w_q;
  logic [W_IN:0]        w_mask;
  logic [W_IN:0]        w_frac;
  logic [W_IN:0]        w_half;
  round_flags_t         w_flags;
  logic                 w_r;
  logic signed [W_IN:0] w_y;
  logic                 w_hi;
  logic                 w_lo;
  logic [W_OUT-1:0]     w_dout;

  logic signed [W_IN:0] r_q;
  logic                 r_r;
  logic [W_OUT-1:0]     r_dout;
  logic                 r_sat;

  // The extra top bit keeps the floor value and the +1 carry from wrapping.
  always_comb begin
    w_ext  = (IS_SIGNED != 0) ? {i_din[W_IN-1], i_din} : {1'b0, i_din};
    w_q    = w_ext >>> i_shift;
    w_mask = (P_ONE << i_shift) - P_ONE;
    w_frac = w_ext & w_mask;
    w_half = (i_shift == '0) ? '0 : (P_ONE << (i_shift - 1'b1));
    w_flags.gt_half = (i_shift != '0) && (w_frac > w_half);
    w_flags.eq_half = (i_shift != '0) && (w_frac == w_half);
    w_flags.nz      = |w_frac;
    w_flags.sign    = (IS_SIGNED != 0) & i_din[W_IN-1];
    w_r = round_up(i_mode, w_flags, w_q[0]);
  end

  always_comb begin
    w_y  = r_q + signed'((W_IN + 1)'(r_r));
    w_hi = w_y > P_MAX;
    w_lo = w_y < P_MIN;
    if (w_hi) begin
      w_dout = P_MAX[W_OUT-1:0];
    end else if (w_lo) begin
      w_dout = P_MIN[W_OUT-1:0];
    end else begin
      w_dout = w_y[W_OUT-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_r    <= 1'b0;
      r_dout <= '0;
      r_sat  <= 1'b0;
    end else begin
      if (i_ld1) begin
        r_q <= w_q;
        r_r <= w_r;
      end
      if (i_ld2) begin
        r_dout <= w_dout;
        r_sat  <= w_hi | w_lo;
      end
    end
  end

  assign o_dout = r_dout;
  assign o_sat  = r_sat;

endmodule

// File: rtl/round_sat_stream.sv
// rtl/round_sat_stream.sv - multi-lane round/saturate stream with shared handshake
// Owns the two-stage valid pipeline, lane instances and per-lane saturation counters.
module round_sat_stream
  import round_pkg::*;
#(
  parameter int W_IN      = 24,
  parameter int W_OUT     = 16,
  parameter int N_CH      = 4,
  parameter int IS_SIGNED = 1,
  parameter int SHIFT_W   = 5,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [N_CH*W_IN-1:0]    s_data,
  input  logic [SHIFT_W-1:0]      s_shift,
  input  logic [2:0]              s_mode,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_CH*W_OUT-1:0]   m_data,
  output logic [N_CH-1:0]         m_sat,
  input  logic                    clr_cnt,
  output logic [N_CH*CNT_W-1:0]   sat_cnt
);

  if (W_OUT > W_IN) begin : g_width_check
    $error("round_sat_stream: W_OUT must not exceed W_IN");
  end

  localparam logic [SHIFT_W-1:0] P_SH_MAX = SHIFT_W'(W_IN);

  logic               r_v1;
  logic               r_v2;
  logic               w_en1;
  logic               w_en2;
  logic               w_acc;
  logic               w_ld2;
  logic               w_fire;
  logic [SHIFT_W-1:0] w_shift;

  // Ready depends only on local state and m_ready, so a full pipe drains with no bubble.
  assign w_en2   = ~r_v2 | m_ready;
  assign w_en1   = ~r_v1 | w_en2;
  assign s_ready = w_en1;
  assign w_acc   = s_valid & w_en1;
  assign w_ld2   = r_v1 & w_en2;
  assign w_fire  = r_v2 & m_ready;
  assign m_valid = r_v2;
  assign w_shift = (s_shift > P_SH_MAX) ? P_SH_MAX : s_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_en1) r_v1 <= s_valid;
      if (w_en2) r_v2 <= r_v1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    logic [CNT_W-1:0] r_cnt;

    round_sat_lane #(
      .W_IN      (W_IN),
      .W_OUT     (W_OUT),
      .IS_SIGNED (IS_SIGNED),
      .SHIFT_W   (SHIFT_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_ld1   (w_acc),
      .i_ld2   (w_ld2),
      .i_din   (s_data[k*W_IN +: W_IN]),
      .i_shift (w_shift),
      .i_mode  (s_mode),
      .o_dout  (m_data[k*W_OUT +: W_OUT]),
      .o_sat   (m_sat[k])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (clr_cnt) begin
        r_cnt <= '0;
      end else if (w_fire && m_sat[k] && !(&r_cnt)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign sat_cnt[k*CNT_W +: CNT_W] = r_cnt;
  end

endmodule

// File: tb/tb_round_sat_stream.sv
// tb/tb_round_sat_stream.sv - directed vectors for round_sat_stream
module tb_round_sat_stream;
  localparam int W_IN = 24, W_OUT = 16, N_CH = 4, SHIFT_W = 5, CNT_W = 8;

  logic                  clk;
  logic                  rst_n;
  logic                  s_valid;
  logic                  s_ready;
  logic [N_CH*W_IN-1:0]  s_data;
  logic [SHIFT_W-1:0]    s_shift;
  logic [2:0]            s_mode;
  logic                  m_valid;
  logic                  m_ready;
  logic [N_CH*W_OUT-1:0] m_data;
  logic [N_CH-1:0]       m_sat;
  logic                  clr_cnt;
  logic [N_CH*CNT_W-1:0] sat_cnt;

  round_sat_stream #(
    .W_IN(W_IN), .W_OUT(W_OUT), .N_CH(N_CH), .IS_SIGNED(1), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_shift(s_shift), .s_mode(s_mode), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sat(m_sat), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] d4(input logic [23:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  function automatic logic [63:0] q4(input logic [15:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  function automatic logic [95:0] ramp(input int i);
    logic [23:0] a;
    a = 24'(i) << 8;
    return d4(a, -a, a | 24'h000080, 24'h7F007F + a);
  endfunction

  function automatic logic [63:0] ramp_exp(input int i);
    logic [15:0] v;
    v = 16'(i);
    return q4(v, -v, v + 16'(i & 1), 16'h7F00 + v);
  endfunction

  // Entered just after a rising edge with an empty pipe and m_ready=1.
  task automatic beat(input logic [95:0] din, input logic [4:0] sh, input logic [2:0] md,
                      input logic [63:0] exp_d, input logic [3:0] exp_s, input string tag,
                      input bit clr_out);
    s_data = din; s_shift = sh; s_mode = md; s_valid = 1'b1;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(s_ready), 64'(1));
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = '0;
    check({tag, "_lat1"}, 64'(m_valid), 64'(0));
    @(posedge clk); #1;
    check({tag, "_lat2"}, 64'(m_valid), 64'(1));
    check({tag, "_data"}, m_data, exp_d);
    check({tag, "_sat"}, 64'(m_sat), 64'(exp_s));
    if (clr_out) clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, got, inflight;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_shift = '0; s_mode = '0;
    m_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_mvalid", 64'(m_valid), 64'(0));
    check("rst_mdata", m_data, 64'(0));
    check("rst_msat", 64'(m_sat), 64'(0));
    check("rst_cnt", 64'(sat_cnt), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rdy_after_rst", 64'(s_ready), 64'(1));

    beat(d4(24'h000280, 24'h000380, 24'hFFFD80, 24'h000240), 5'd8, 3'd0,
         q4(16'h0002, 16'h0004, 16'hFFFE, 16'h0002), 4'b0000, "rne", 1'b0);
    beat(d4(24'h000280, 24'h000380, 24'hFFFD80, 24'h000240), 5'd8, 3'd5,
         q4(16'h0002, 16'h0004, 16'hFFFE, 16'h0002), 4'b0000, "mode5", 1'b0);
    beat(d4(24'h000280, 24'hFFFD80, 24'h000240, 24'h0), 5'd8, 3'd1,
         q4(16'h0003, 16'hFFFD, 16'h0002, 16'h0), 4'b0000, "rhaz", 1'b0);
    beat(d4(24'h000280, 24'hFFFD80, 24'h000240, 24'h0), 5'd8, 3'd2,
         q4(16'h0002, 16'hFFFD, 16'h0002, 16'h0), 4'b0000, "floor", 1'b0);
    beat(d4(24'h000280, 24'hFFFD80, 24'h000240, 24'h0), 5'd8, 3'd3,
         q4(16'h0002, 16'hFFFE, 16'h0002, 16'h0), 4'b0000, "trunc", 1'b0);
    beat(d4(24'h000280, 24'hFFFD80, 24'h000240, 24'h0), 5'd8, 3'd4,
         q4(16'h0003, 16'hFFFE, 16'h0003, 16'h0), 4'b0000, "ceil", 1'b0);
    beat(d4(24'h7FFFFF, 24'h800000, 24'h007FFF, 24'hFF8000), 5'd0, 3'd0,
         q4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000), 4'b0011, "sat_sh0", 1'b0);
    beat(d4(24'h7FFFFF, 24'h7FFF80, 24'h800000, 24'h7FFF7F), 5'd8, 3'd0,
         q4(16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF), 4'b0011, "sat_carry", 1'b0);
    beat(d4(24'h800000, 24'h7FFFFF, 24'h000001, 24'hFFFFFF), 5'd24, 3'd2,
         q4(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF), 4'b0000, "sh24_floor", 1'b0);
    beat(d4(24'h800000, 24'hC00000, 24'h400000, 24'hFFFFFF), 5'd24, 3'd0,
         q4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 4'b0000, "sh24_rne", 1'b0);
    beat(d4(24'h800000, 24'h7FFFFF, 24'h000001, 24'hFFFFFF), 5'd31, 3'd2,
         q4(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF), 4'b0000, "sh31_clamp", 1'b0);
    beat(d4(24'h001234, 24'hFFEDCC, 24'h000000, 24'hFFFFFF), 5'd0, 3'd0,
         q4(16'h1234, 16'hEDCC, 16'h0000, 16'hFFFF), 4'b0000, "sh0_pass", 1'b0);

    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("cnt_clr", 64'(sat_cnt), 64'(0));
    for (int i = 0; i < 3; i++)
      beat(d4(24'h7FFFFF, 24'h0, 24'h0, 24'h0), 5'd0, 3'd0,
           q4(16'h7FFF, 16'h0, 16'h0, 16'h0), 4'b0001, "cnt_beat", 1'b0);
    check("cnt_three", 64'(sat_cnt), 64'(32'h0000_0003));
    beat(d4(24'h7FFFFF, 24'h0, 24'h0, 24'h0), 5'd0, 3'd0,
         q4(16'h7FFF, 16'h0, 16'h0, 16'h0), 4'b0001, "cnt_clr_beat", 1'b1);
    check("cnt_clr_prio", 64'(sat_cnt), 64'(0));

    s_data = d4(24'h7FFFFF, 24'h0, 24'h0, 24'h0); s_shift = 5'd0; s_mode = 3'd0;
    s_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1 s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("cnt_hold_max", 64'(sat_cnt), 64'(32'h0000_00FF));

    sent = 0; got = 0; inflight = 0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      if (sent < 16) begin
        s_valid = 1'b1; s_data = ramp(sent); s_shift = 5'd8; s_mode = 3'd0;
      end else begin
        s_valid = 1'b0;
      end
      m_ready = (cyc >= 6 && cyc < 11) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_rdy", 64'(s_ready), 64'(!(inflight == 2 && !m_ready)));
      if (m_valid && m_ready) begin
        check("bp_data", m_data, ramp_exp(got));
        got++; inflight--;
      end
      if (s_valid && s_ready) begin
        sent++; inflight++;
      end
      @(posedge clk); #1;
    end
    check("bp_count", 64'(got), 64'(16));
    s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;

    m_ready = 1'b0;
    s_data = d4(24'h7FFFFF, 24'h0, 24'h0, 24'h0); s_shift = 5'd0; s_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("fill_mvalid", 64'(m_valid), 64'(1));
    check("fill_srdy", 64'(s_ready), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("arst_mvalid", 64'(m_valid), 64'(0));
    check("arst_mdata", m_data, 64'(0));
    check("arst_msat", 64'(m_sat), 64'(0));
    check("arst_cnt", 64'(sat_cnt), 64'(0));
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(m_valid), 64'(0));
    end
    @(posedge clk); #1;
    beat(d4(24'h000280, 24'h000380, 24'hFFFD80, 24'h000240), 5'd8, 3'd0,
         q4(16'h0002, 16'h0004, 16'hFFFE, 16'h0002), 4'b0000, "post_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
